// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Build option: SEQ_DIVIDER_SIGNED_EN (two's-complement operands) is handled in seq_divider.sv.
package seq_divider_pkg;

  // Controller states: waiting, iterating, and the one-cycle result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest supported operand; the divide-by-zero pattern is sliced from this.
  localparam int MAX_WIDTH = 64;

  // Quotient reported on divide by zero: all ones at any width.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Iteration counter width, which must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor at WIDTH+1 bits, keep the difference or restore.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             in_bit,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract. The shifted remainder is always below 2*divisor, so the
  // WIDTH+1-bit difference fits, and its top bit is the sign.
  always_comb begin
    shifted  = {rem, in_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with a start/done handshake: one quotient bit
// per clock. Results hold until the next accepted start.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division); otherwise the block is purely unsigned.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import seq_divider_pkg::*;

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q = DBZ_QUOTIENT[WIDTH-1:0];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_q;      // dividend shift register, MSB feeds the step
  logic [WIDTH-1:0] dvs_q;      // captured divisor (magnitude when signed)
  logic [WIDTH-1:0] load_dvd;
  logic [WIDTH-1:0] load_dvs;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             dbz_in;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quot;               // operand signs differ
  logic neg_rem;                // dividend was negative

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
`endif

  // The remainder output register doubles as the partial remainder.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (remainder),
    .divisor  (dvs_q),
    .in_bit   (dvd_q[WIDTH-1]),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Operand conditioning at capture and result fix-up at DONE entry.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    dbz_in = (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    load_dvs = mag(divisor);
    // Divide by zero keeps the raw dividend, since it is returned as remainder.
    load_dvd = dbz_in ? dividend : mag(dividend);
    fin_q    = neg_quot ? -quotient  : quotient;
    fin_r    = neg_rem  ? -remainder : remainder;
`else
    load_dvs = divisor;
    load_dvd = dividend;
    fin_q    = quotient;
    fin_r    = remainder;
`endif
    if (div_by_zero) begin
      fin_q = DBZ_Q;
      fin_r = dvd_q;
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Divide by zero enters CALC with an empty count: no iterations,
            // one settling cycle, then the fixed result on DONE entry.
            state       <= CALC;
            cnt         <= dbz_in ? '0 : CNT_W'(WIDTH);
            busy        <= ~dbz_in;
            dvd_q       <= load_dvd;
            dvs_q       <= load_dvs;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= dbz_in;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quot    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem     <= dividend[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            remainder <= step_rem;
            quotient  <= {quotient[WIDTH-2:0], step_q};
            dvd_q     <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt       <= cnt - CNT_W'(1);
            busy      <= (cnt != CNT_W'(1));
          end else begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= fin_q;
            remainder <= fin_r;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases with literal results,
// then randomized traffic compared every cycle against a timing/arithmetic model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: plain integer division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    z  = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sa == -(1 << (W - 1)) && sb == -1) begin
      q = a;
      r = '0;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Model: edge counter, accept edge, done cycle and expected results.
  int           cyc     = 0;
  int           acc     = 0;
  int           doneat  = 0;
  bit           have_op = 1'b0;
  bit           run_cmp = 1'b0;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic         m_z;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_op = 1'b0;
    end else if (start && (!have_op || (cyc - 1) >= doneat)) begin
      acc     = cyc;
      doneat  = cyc + ((divisor == '0) ? 1 : W + 1);
      ref_div(dividend, divisor, m_q, m_r, m_z);
      have_op = 1'b1;
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      if (!rst_n || !have_op) begin
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));
        check("idle_quotient", 32'(quotient), 32'(0));
        check("idle_remainder", 32'(remainder), 32'(0));
        check("idle_dbz", 32'(div_by_zero), 32'(0));
      end else begin
        check("busy", 32'(busy), 32'(!m_z && cyc >= acc && cyc < acc + W));
        check("done", 32'(done), 32'(cyc == doneat));
        if (cyc >= doneat) begin
          check("quotient", 32'(quotient), 32'(m_q));
          check("remainder", 32'(remainder), 32'(m_r));
          check("dbz", 32'(div_by_zero), 32'(m_z));
        end else if (cyc == acc) begin
          check("clr_quotient", 32'(quotient), 32'(0));
          check("clr_remainder", 32'(remainder), 32'(0));
        end
      end
    end
  end

  // Present operands with start for one cycle; returns just after the accept edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check latency in edges from accept, busy cycles
  // and the literal results. With poke, start and operands are disturbed mid-CALC.
  task automatic finish_op(input string nm, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int elat, input int ebusy, input bit poke);
    int n  = 0;
    int nb = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        n++;
        #2;
        if (poke) begin
          start    = (n <= 2);
          dividend = W'($urandom_range(0, 15));
          divisor  = W'($urandom_range(0, 15));
        end
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'(1));
    check({nm, "_latency"}, 32'(n), 32'(elat));
    check({nm, "_busy_cycles"}, 32'(nb), 32'(ebusy));
    check({nm, "_quotient"}, 32'(quotient), 32'(eq));
    check({nm, "_remainder"}, 32'(remainder), 32'(er));
    check({nm, "_dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #2;
    run_cmp = 1'b1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_dbz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;

`ifdef SEQ_DIVIDER_SIGNED_EN
    launch(4'b1001, 4'd2);                          // -7 / 2
    finish_op("neg7_div_2", 4'hD, 4'hF, 1'b0, W + 1, W, 1'b0);
    launch(4'b1000, 4'b1111);                       // -8 / -1 wraps
    finish_op("neg8_div_neg1", 4'h8, 4'h0, 1'b0, W + 1, W, 1'b0);
    launch(4'd7, 4'd0);
    finish_op("div7_0", 4'hF, 4'd7, 1'b1, 1, 0, 1'b0);
`else
    launch(4'd13, 4'd3);
    finish_op("div13_3", 4'd4, 4'd1, 1'b0, W + 1, W, 1'b0);
    launch(4'd7, 4'd0);
    finish_op("div7_0", 4'd15, 4'd7, 1'b1, 1, 0, 1'b0);

    // Back-to-back: start stays high through the first operation's done pulse.
    @(posedge clk); #2;
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk); #2;
    dividend = 4'd2;
    divisor  = 4'd5;
    finish_op("b2b_first", 4'd15, 4'd0, 1'b0, W + 1, W, 1'b0);
    @(posedge clk); #2;
    start = 1'b0;
    finish_op("b2b_second", 4'd0, 4'd2, 1'b0, W + 1, W, 1'b0);

    // start pulsed and operands changed while busy must not disturb 9/2.
    launch(4'd9, 4'd2);
    finish_op("div9_2_poked", 4'd4, 4'd1, 1'b0, W + 1, W, 1'b1);
    start = 1'b0;

    // Reset in the middle of 14/3 clears everything at once.
    launch(4'd14, 4'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient), 32'(0));
    check("midrst_remainder", 32'(remainder), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    launch(4'd14, 4'd3);
    finish_op("div14_3", 4'd4, 4'd2, 1'b0, W + 1, W, 1'b0);
`endif

    // Random traffic: starts at any time, zero divisors, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom_range(0, 15));
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      rst_n    = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    @(negedge clk);
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
